dft_result_tx: RTL and testbench

DFT_RESULT_TX -- requirements
Module: dft_result_tx

---
 rtl/dft_result_tx.sv | 142 ++++++++++++++
 tb/tb_dft_result_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_result_tx.sv
// Serialises one captured DFT frame (header, payload bytes, XOR checksum)
// into an SPI slave transmit register using a valid/ack byte handshake.
module dft_result_tx #(
  parameter int                   SPI_WIDTH = 8,
  parameter int                   DFT_WIDTH = 16,
  parameter int                   BIN_NUM   = 1,
  parameter logic [SPI_WIDTH-1:0] HDR       = SPI_WIDTH'(8'hA5)
) (
  input  logic                             i_sys_clk,
  input  logic                             i_sys_rst,
  input  logic [BIN_NUM*2*DFT_WIDTH-1:0]   i_X,
  input  logic                             i_done,
  output logic [SPI_WIDTH-1:0]             o_tx_data,
  output logic                             o_tx_valid,
  input  logic                             i_tx_ack,
  output logic                             o_busy,
  output logic                             o_overrun,
  input  logic                             i_clr_ovr
);

  localparam int FRAME_W = BIN_NUM * 2 * DFT_WIDTH;
  localparam int NBYTES  = FRAME_W / SPI_WIDTH;
  localparam int CNT_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } state_t;

  state_t               state_q,   state_d;
  logic [SPI_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [SPI_WIDTH-1:0] csum_q,    csum_d;
  logic [FRAME_W-1:0]   frame_q,   frame_d;
  logic                 ovr_q,     ovr_d;

  logic busy;
  logic accept;
  logic capture;
  logic [SPI_WIDTH-1:0] top_byte;

  // A byte is on offer in every non-idle state, so valid and busy coincide
  // and there is never a gap between consecutive bytes.
  assign busy     = (state_q != ST_IDLE);
  assign accept   = busy && i_tx_ack;
  assign capture  = i_done && !busy;
  assign top_byte = frame_q[FRAME_W-1 -: SPI_WIDTH];

  assign o_busy     = busy;
  assign o_tx_valid = busy;
  assign o_tx_data  = tx_data_q;
  assign o_overrun  = ovr_q;

  // NOTE: every variable gets its hold value before the case statement so
  // no path through the block leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    frame_d   = frame_q;

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d   = ST_HDR;
          tx_data_d = HDR;
          cnt_d     = '0;
          csum_d    = '0;
          frame_d   = i_X;
        end
      end
      ST_HDR: begin
        if (accept) begin
          state_d   = ST_DATA;
          tx_data_d = top_byte;
          frame_d   = frame_q << SPI_WIDTH;
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ tx_data_q;
          if (cnt_q == LAST_BYTE) begin
            state_d   = ST_CSUM;
            tx_data_d = csum_d;
            cnt_d     = '0;
          end else begin
            tx_data_d = top_byte;
            frame_d   = frame_q << SPI_WIDTH;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d   = ST_IDLE;
          tx_data_d = '0;
          csum_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set has priority over clear; a coincident CSUM ack still counts as busy.
  always_comb begin
    ovr_d = ovr_q;
    if (i_done && busy) begin
      ovr_d = 1'b1;
    end else if (i_clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      ovr_q     <= ovr_d;
    end
  end

  // NOTE: the frame buffer is deliberately left out of reset; it is always
  // reloaded on capture before any of its contents are sent.
  always_ff @(posedge i_sys_clk) begin
    frame_q <= frame_d;
  end

endmodule

// File: tb/tb_dft_result_tx.sv
// Scoreboard bench for dft_result_tx: one single-bin and one two-bin instance
// share clock and reset; a negedge monitor checks every acked byte.
module tb_dft_result_tx;

  logic clk;
  logic rst_n;

  logic [31:0] a_x;
  logic        a_done, a_ack, a_clr;
  logic [7:0]  a_data;
  logic        a_valid, a_busy, a_ovr;

  logic [63:0] b_x;
  logic        b_done, b_ack, b_clr;
  logic [7:0]  b_data;
  logic        b_valid, b_busy, b_ovr;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int total = 0;
  int bad   = 0;

  dft_result_tx #(.SPI_WIDTH(8), .DFT_WIDTH(16), .BIN_NUM(1), .HDR(8'hA5)) u_dut_a (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .i_X       (a_x),
    .i_done    (a_done),
    .o_tx_data (a_data),
    .o_tx_valid(a_valid),
    .i_tx_ack  (a_ack),
    .o_busy    (a_busy),
    .o_overrun (a_ovr),
    .i_clr_ovr (a_clr)
  );

  dft_result_tx #(.SPI_WIDTH(8), .DFT_WIDTH(16), .BIN_NUM(2), .HDR(8'hA5)) u_dut_b (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .i_X       (b_x),
    .i_done    (b_done),
    .o_tx_data (b_data),
    .o_tx_valid(b_valid),
    .i_tx_ack  (b_ack),
    .o_busy    (b_busy),
    .o_overrun (b_ovr),
    .i_clr_ovr (b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a6(input logic [47:0] bytes);
    for (int i = 5; i >= 0; i--) exp_a.push_back(bytes[i*8 +: 8]);
  endtask

  task automatic push_b10(input logic [79:0] bytes);
    for (int i = 9; i >= 0; i--) exp_b.push_back(bytes[i*8 +: 8]);
  endtask

  // Wait (bounded) for a byte on DUT a, hold off dly cycles, then ack once.
  task automatic ack_a(input int dly);
    int n = 0;
    while (!a_valid && n < 50) begin
      tick();
      n++;
    end
    if (!a_valid) begin
      check("a_valid_timeout", {63'd0, a_valid}, 64'd1);
      return;
    end
    repeat (dly) tick();
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
  endtask

  task automatic ack_b(input int dly);
    int n = 0;
    while (!b_valid && n < 50) begin
      tick();
      n++;
    end
    if (!b_valid) begin
      check("b_valid_timeout", {63'd0, b_valid}, 64'd1);
      return;
    end
    repeat (dly) tick();
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
  endtask

  task automatic pulse_a_done();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
  endtask

  // Monitor: a byte is consumed when valid and ack are both seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n && a_valid && a_ack) begin
      if (exp_a.size() == 0) check("a_unexpected_byte", {56'd0, a_data}, 64'hFFFF);
      else check("a_byte", {56'd0, a_data}, {56'd0, exp_a.pop_front()});
    end
    if (rst_n && b_valid && b_ack) begin
      if (exp_b.size() == 0) check("b_unexpected_byte", {56'd0, b_data}, 64'hFFFF);
      else check("b_byte", {56'd0, b_data}, {56'd0, exp_b.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    rst_n  = 1'b0;
    a_x    = '0; a_done = 1'b0; a_ack = 1'b0; a_clr = 1'b0;
    b_x    = '0; b_done = 1'b0; b_ack = 1'b0; b_clr = 1'b0;
    #12;
    check("rst_a_data",  {56'd0, a_data}, 64'd0);
    check("rst_a_valid", {63'd0, a_valid}, 64'd0);
    check("rst_a_busy",  {63'd0, a_busy}, 64'd0);
    check("rst_a_ovr",   {63'd0, a_ovr}, 64'd0);
    check("rst_b_valid", {63'd0, b_valid}, 64'd0);

    // Frame 1: done in the very first cycle after reset release, ack after 3.
    // Checksum 00^02^FF^FB = 06.
    a_x = {16'h0002, 16'hFFFB};
    push_a6(48'hA5_00_02_FF_FB_06);
    @(negedge clk);
    rst_n  = 1'b1;
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("f1_busy_after_capture", {63'd0, a_busy}, 64'd1);
    check("f1_hdr_on_bus",         {56'd0, a_data}, 64'hA5);
    repeat (6) ack_a(3);
    check("f1_busy_end",  {63'd0, a_busy}, 64'd0);
    check("f1_valid_end", {63'd0, a_valid}, 64'd0);

    // Frame 2: ack held high throughout, including while idle.
    a_ack = 1'b1;
    repeat (2) tick();
    check("idle_ack_ignored", {63'd0, a_valid}, 64'd0);
    push_a6(48'hA5_00_02_FF_FB_06);
    pulse_a_done();
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_valid) vcnt++;
      if (i == 5) check("f2_sixth_valid", {63'd0, a_valid}, 64'd1);
      tick();
    end
    a_ack = 1'b0;
    check("f2_valid_cycles", 64'(vcnt), 64'd6);
    check("f2_busy_end", {63'd0, a_busy}, 64'd0);

    // Frame 3: second done while the third byte is pending.
    push_a6(48'hA5_00_02_FF_FB_06);
    pulse_a_done();
    ack_a(1);
    ack_a(1);
    a_x = 32'hDEAD_BEEF;
    pulse_a_done();
    check("f3_ovr_set",        {63'd0, a_ovr}, 64'd1);
    check("f3_byte_unchanged", {56'd0, a_data}, 64'h02);
    a_done = 1'b1;
    a_clr  = 1'b1;
    tick();
    a_done = 1'b0;
    a_clr  = 1'b0;
    check("f3_set_beats_clr", {63'd0, a_ovr}, 64'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("f3_ovr_cleared", {63'd0, a_ovr}, 64'd0);
    repeat (4) ack_a(1);
    check("f3_busy_end", {63'd0, a_busy}, 64'd0);

    // Frame 4: done coincident with the checksum ack.
    a_x = {16'h0002, 16'hFFFB};
    push_a6(48'hA5_00_02_FF_FB_06);
    pulse_a_done();
    repeat (5) ack_a(1);
    check("f4_csum_pending", {63'd0, a_valid}, 64'd1);
    a_ack  = 1'b1;
    a_done = 1'b1;
    tick();
    a_ack  = 1'b0;
    a_done = 1'b0;
    check("f4_ovr",  {63'd0, a_ovr}, 64'd1);
    check("f4_busy", {63'd0, a_busy}, 64'd0);
    repeat (3) tick();
    check("f4_no_new_hdr", {63'd0, a_valid}, 64'd0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;

    // Frame 5: reset after two bytes acked, then a fresh frame.
    push_a6(48'hA5_00_02_FF_FB_06);
    pulse_a_done();
    ack_a(0);
    ack_a(0);
    rst_n = 1'b0;
    #1;
    check("f5_rst_data",  {56'd0, a_data}, 64'd0);
    check("f5_rst_valid", {63'd0, a_valid}, 64'd0);
    check("f5_rst_busy",  {63'd0, a_busy}, 64'd0);
    exp_a.delete();
    tick();
    rst_n = 1'b1;
    tick();
    // 12^34^80^01 = A7
    a_x = {16'h1234, 16'h8001};
    push_a6(48'hA5_12_34_80_01_A7);
    pulse_a_done();
    check("f5_hdr_first", {56'd0, a_data}, 64'hA5);
    repeat (6) ack_a(0);
    check("f5_busy_end", {63'd0, a_busy}, 64'd0);

    // Two-bin frame. Checksum 00^01^FF^FC^00^01^00^01 = 02.
    b_x = {16'h0001, 16'hFFFC, 16'h0001, 16'h0001};
    push_b10(80'hA5_00_01_FF_FC_00_01_00_01_02);
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    repeat (10) ack_b(1);
    check("b_busy_end", {63'd0, b_busy}, 64'd0);
    check("b_ovr",      {63'd0, b_ovr}, 64'd0);

    repeat (3) tick();
    check("a_queue_empty", 64'(exp_a.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
